// File: rtl/irq_ctrl.sv
// Interrupt controller for CP0 HWInt[5:0]: synchronized edge/level capture, enable mask, status encoder.
// Define IRQ_TIMER_EN to compile in the countdown timer that takes over line 0.
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq_in,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [5:0]  hwint
);
  localparam int unsigned NumLines = 6;
  localparam int unsigned DataW    = 32;

  logic [SYNC_STAGES-1:0][NumLines-1:0] syncQ;
  logic [NumLines-1:0] syncOut, lineIn, linePrev;
  logic [NumLines-1:0] pend, pendNext, enReg, modeReg;
  logic [2:0]          statIdx;
  logic                wrPend, wrEn, wrMode, timerFire;

  assign wrPend  = we && (addr == 3'd0);
  assign wrEn    = we && (addr == 3'd1);
  assign wrMode  = we && (addr == 3'd2);
  assign syncOut = syncQ[SYNC_STAGES-1];

`ifdef IRQ_TIMER_EN
  // Line 0 belongs to the timer, so its external input is dropped here.
  assign lineIn = syncOut & ~NumLines'(1);
`else
  assign lineIn = syncOut;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncQ    <= '0;
      linePrev <= '0;
      pend     <= '0;
      enReg    <= '0;
      modeReg  <= '0;
    end else begin
      syncQ    <= {syncQ[SYNC_STAGES-2:0], irq_in};
      linePrev <= lineIn;
      pend     <= pendNext;
      if (wrEn)   enReg   <= wd[NumLines-1:0];
      if (wrMode) modeReg <= wd[NumLines-1:0];
    end
  end

  // Edge lines: set on rising edge (set beats a same-cycle clear); level lines track the input.
  always_comb begin
    pendNext = pend;
    for (int i = 0; i < NumLines; i++) begin
      if (modeReg[i]) begin
        if (wrPend && wd[i]) pendNext[i] = 1'b0;
        if (lineIn[i] && !linePrev[i]) pendNext[i] = 1'b1;
      end else begin
        pendNext[i] = lineIn[i];
      end
    end
    if (timerFire) pendNext[0] = 1'b1;
  end

  assign hwint = pend & enReg;

  always_comb begin
    statIdx = '0;
    for (int i = 0; i < NumLines; i++) begin
      if (hwint[i]) statIdx = 3'(i);
    end
  end

`ifdef IRQ_TIMER_EN
  typedef enum logic {IDLE, RUN} timerState_t;

  timerState_t      timerState, timerStateNext;
  logic [DataW-1:0] presetReg, countReg, countNext;
  logic             ctrlEna, ctrlAuto, enaNext, autoNext;
  logic             wrPreset, wrCtrl;

  assign wrPreset = we && (addr == 3'd4);
  assign wrCtrl   = we && (addr == 3'd6);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timerState <= IDLE;
      presetReg  <= '0;
      countReg   <= '0;
      ctrlEna    <= 1'b0;
      ctrlAuto   <= 1'b0;
    end else begin
      timerState <= timerStateNext;
      countReg   <= countNext;
      ctrlEna    <= enaNext;
      ctrlAuto   <= autoNext;
      if (wrPreset) presetReg <= wd;
    end
  end

  // A CTRL write takes priority over counting in the same cycle.
  always_comb begin
    timerStateNext = timerState;
    countNext      = countReg;
    enaNext        = ctrlEna;
    autoNext       = ctrlAuto;
    timerFire      = 1'b0;
    if (wrCtrl) begin
      enaNext  = wd[0];
      autoNext = wd[1];
      if (wd[0]) begin
        countNext      = presetReg;
        timerStateNext = RUN;
      end else begin
        timerStateNext = IDLE;
      end
    end else begin
      case (timerState)
        RUN: begin
          if (countReg > DataW'(1)) begin
            countNext = countReg - DataW'(1);
          end else begin
            timerFire = 1'b1;
            if (ctrlAuto) begin
              countNext = presetReg;
            end else begin
              countNext      = '0;
              enaNext        = 1'b0;
              timerStateNext = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic unusedWd;
  assign timerFire = 1'b0;
  assign unusedWd  = ^wd[DataW-1:NumLines];
`endif

  always_comb begin
    rd = '0;
    case (addr)
      3'd0: rd = DataW'(pend);
      3'd1: rd = DataW'(enReg);
      3'd2: rd = DataW'(modeReg);
      3'd3: rd = {|hwint, 28'd0, statIdx};
`ifdef IRQ_TIMER_EN
      3'd4: rd = presetReg;
      3'd5: rd = countReg;
      3'd6: rd = {30'd0, ctrlAuto, ctrlEna};
`endif
      default: rd = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes model predictions, a negedge monitor compares.
module tb_irq_ctrl;
  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  irq_in = '0;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [5:0]  hwint;

  irq_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .we(we),
    .addr(addr), .wd(wd), .rd(rd), .hwint(hwint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  hw;
    logic [31:0] rdv;
    logic [2:0]  a;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: registers plus a history of sampled input words.
  logic [5:0]  mPend, mEn, mMode;
  logic [5:0]  hist[$];
  int          edgeN;
  logic [31:0] mPreset, mCount;
  logic        mEna, mAuto;
  int          fireEdge;
  logic [5:0]  irqV;

  function automatic void modelReset();
    mPend = '0; mEn = '0; mMode = '0;
    hist.delete();
    for (int k = 0; k <= S; k++) hist.push_back(6'd0);
    edgeN = 0;
    mPreset = '0; mCount = '0; mEna = 1'b0; mAuto = 1'b0; fireEdge = 0;
  endfunction

  function automatic logic [31:0] mRead(input logic [2:0] a);
    logic [5:0]  h;
    logic [31:0] stat;
    logic        found;
    h = mPend & mEn;
    stat = '0;
    found = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!found && h[i]) begin
        found = 1'b1;
        stat = {1'b1, 28'd0, 3'(i)};
      end
    end
    case (a)
      3'd0: return {26'd0, mPend};
      3'd1: return {26'd0, mEn};
      3'd2: return {26'd0, mMode};
      3'd3: return stat;
`ifdef IRQ_TIMER_EN
      3'd4: return mPreset;
      3'd5: return mCount;
      3'd6: return {30'd0, mAuto, mEna};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Effect of one rising edge. s is the sample taken S edges ago, p the one before it.
  function automatic void modelEdge(input logic w, input logic [2:0] a, input logic [31:0] d,
                                    input logic [5:0] irq);
    logic [5:0] s, p, np;
    logic       fire;
    s = hist[S-1];
    p = hist[S];
    np = mPend;
    fire = 1'b0;
`ifdef IRQ_TIMER_EN
    s[0] = 1'b0;
    p[0] = 1'b0;
`endif
    edgeN++;
    for (int i = 0; i < 6; i++) begin
      if (mMode[i]) begin
        if (s[i] && !p[i]) np[i] = 1'b1;
        else if (w && a == 3'd0 && d[i]) np[i] = 1'b0;
      end else begin
        np[i] = s[i];
      end
    end
`ifdef IRQ_TIMER_EN
    if (w && a == 3'd6) begin
      mEna = d[0];
      mAuto = d[1];
      if (d[0]) begin
        mCount = mPreset;
        fireEdge = edgeN + ((mPreset == 0) ? 1 : int'(mPreset));
      end
    end else if (mEna) begin
      if (edgeN == fireEdge) begin
        fire = 1'b1;
        if (mAuto) begin
          mCount = mPreset;
          fireEdge = edgeN + ((mPreset == 0) ? 1 : int'(mPreset));
        end else begin
          mCount = '0;
          mEna = 1'b0;
        end
      end else begin
        mCount = 32'(fireEdge - edgeN);
      end
    end
    if (w && a == 3'd4) mPreset = d;
`endif
    if (fire) np[0] = 1'b1;
    if (w && a == 3'd1) mEn = d[5:0];
    if (w && a == 3'd2) mMode = d[5:0];
    mPend = np;
    hist.push_front(irq);
    void'(hist.pop_back());
  endfunction

  task automatic pushExp(input logic [2:0] a);
    exp_t e;
    e.hw = mPend & mEn;
    e.rdv = mRead(a);
    e.a = a;
    e.cyc = cyc;
    expQ.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic w, input logic [2:0] a, input logic [31:0] d);
    we = w; addr = a; wd = d; irq_in = irqV;
    pushExp(a);
    @(posedge clk);
    modelEdge(w, a, d, irqV);
    cyc++;
    #1;
  endtask

  task automatic rdStep(input logic [2:0] a);
    step(1'b0, a, 32'd0);
  endtask

  task automatic wrStep(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, a, d);
  endtask

  task automatic asyncReset(input logic [2:0] a);
    we = 1'b0; addr = a;
    #2 reset = 1'b0;
    modelReset();
    pushExp(a);
    @(posedge clk);
    cyc++;
    #1 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (hwint !== e.hw) begin
        errors++;
        $display("FAIL hwint cyc=%0d got %h expected %h", e.cyc, hwint, e.hw);
      end
      checks++;
      if (rd !== e.rdv) begin
        errors++;
        $display("FAIL rd addr=%0d cyc=%0d got %h expected %h", e.a, e.cyc, rd, e.rdv);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [2:0]  a;
    irqV = '0;
    modelReset();
    @(posedge clk);
    #1 pushExp(3'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 8; k++) rdStep(3'(k));

    // Edge capture on line 2, then software clear.
    wrStep(3'd2, 32'h3F);
    wrStep(3'd1, 32'h04);
    irqV = 6'h04;
    for (int k = 0; k < 3; k++) rdStep(3'd0);
    irqV = 6'h00;
    for (int k = 0; k < 4; k++) rdStep(3'd3);
    wrStep(3'd0, 32'h4);
    rdStep(3'd0);
    rdStep(3'd3);

    // Level capture on line 5; PEND write has no effect while high.
    wrStep(3'd2, 32'h0);
    wrStep(3'd1, 32'h3F);
    irqV = 6'h20;
    for (int k = 0; k < 4; k++) rdStep(3'd0);
    wrStep(3'd0, 32'h20);
    rdStep(3'd0);
    irqV = 6'h00;
    for (int k = 0; k < 4; k++) rdStep(3'd0);

    // Priority/status with pend = 6'h12.
    irqV = 6'h12;
    for (int k = 0; k < 4; k++) rdStep(3'd0);
    rdStep(3'd3);
    wrStep(3'd1, 32'h02);
    rdStep(3'd3);
    wrStep(3'd1, 32'h00);
    rdStep(3'd3);
    irqV = 6'h00;

    // Set/clear collision on line 1.
    wrStep(3'd2, 32'h3F);
    wrStep(3'd1, 32'h3F);
    for (int k = 0; k < 4; k++) rdStep(3'd0);
    irqV = 6'h02;
    rdStep(3'd0);
    rdStep(3'd0);
    wrStep(3'd0, 32'h2);
    rdStep(3'd0);
    rdStep(3'd0);
    irqV = 6'h00;

    // Reset in the middle of activity.
    wrStep(3'd2, 32'h0);
    irqV = 6'h3F;
    for (int k = 0; k < 4; k++) rdStep(3'd3);
    asyncReset(3'd0);
    irqV = 6'h00;
    for (int k = 0; k < 8; k++) rdStep(3'd7 - 3'(k));

`ifdef IRQ_TIMER_EN
    // Auto-reload timer, then one-shot.
    wrStep(3'd1, 32'h1);
    wrStep(3'd4, 32'd5);
    wrStep(3'd6, 32'd3);
    for (int k = 0; k < 16; k++) rdStep((k % 2 == 0) ? 3'd5 : 3'd3);
    wrStep(3'd6, 32'd1);
    for (int k = 0; k < 10; k++) rdStep((k % 2 == 0) ? 3'd6 : 3'd5);
    wrStep(3'd4, 32'd0);
    wrStep(3'd6, 32'd3);
    for (int k = 0; k < 4; k++) rdStep(3'd5);
    wrStep(3'd6, 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) irqV = irqV ^ 6'(1 << $urandom_range(0, 5));
      a = 3'($urandom_range(0, 7));
      d = $urandom();
      if (a == 3'd4) d = 32'($urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) wrStep(a, d);
      else rdStep(a);
    end

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
